// File: rtl/arena_seeder.sv
// arena_seeder: on an accepted start, walks arena rows 0..ARENA_HEIGHT-1 and
// issues one registered row write per clock. The written pattern is CLEAR,
// FILL, RANDOM (xorshift32) or CHECKER, chosen by mode when start is accepted.
//
// Optional feature: define ARENA_SEEDER_SEED_EN to add the seed/seed_load
// ports, which reload the random generator while idle.
//
// Handshake: a run is accepted on a rising edge where start=1 and ready=1.
// While ready=0, start, mode (and seed_load) are ignored. ready drops in the
// cycle after acceptance and returns in the cycle after the last row write.
module arena_seeder #(
  parameter int          ARENA_WIDTH  = 10,
  parameter int          ARENA_HEIGHT = 10,
  parameter logic [31:0] SEED         = 32'h2545F491
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
`ifdef ARENA_SEEDER_SEED_EN
  input  logic [31:0]            seed,
  input  logic                   seed_load,
`endif
  output logic                   ready,
  output logic [9:0]             arena_row_select,
  output logic [ARENA_WIDTH-1:0] arena_columns_new,
  output logic                   arena_columns_write,
  output logic                   state_dbg
);

  // A zero seed would lock xorshift32 at zero forever, so it is replaced.
  localparam logic [31:0] DEFAULT_SEED = 32'h2545F491;
  localparam logic [31:0] SEED_EFF     = (SEED == 32'h0) ? DEFAULT_SEED : SEED;
  localparam int          CHUNKS       = (ARENA_WIDTH + 31) / 32;
  localparam logic [9:0]  LAST_ROW     = 10'(ARENA_HEIGHT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_CLEAR   = 2'd0,
    MODE_FILL    = 2'd1,
    MODE_RANDOM  = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_t;

  state_t      state_q, state_d;
  mode_t       mode_q, mode_d;
  logic [31:0] rng_q, rng_d;
  logic [31:0] rng_src;
  logic        ready_d;
  logic        write_d;
  logic [9:0]  row_d;
  logic [ARENA_WIDTH-1:0] cols_d;
  logic        gen_load;
  mode_t       gen_mode;
  logic [9:0]  gen_row;

  // One xorshift32 step.
  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Rotate left by s using a doubled word so no wrap logic is needed.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] d;
    d = {x, x} << s;
    return d[63:32];
  endfunction

  // Row pattern for a given mode, row parity and random word. Only the row
  // LSB matters for the checkerboard, so only that bit is passed in.
  function automatic logic [ARENA_WIDTH-1:0] make_row(input mode_t m,
                                                      input logic row_lsb,
                                                      input logic [31:0] x);
    logic [CHUNKS*32-1:0]   wide;
    logic [ARENA_WIDTH-1:0] res;
    wide = '0;
    res  = '0;
    case (m)
      MODE_CLEAR: res = '0;
      MODE_FILL:  res = '1;
      MODE_CHECKER: begin
        for (int j = 0; j < ARENA_WIDTH; j++) begin
          res[j] = ((j % 2) == 1) ^ row_lsb;
        end
      end
      MODE_RANDOM: begin
        // Chunk k is the random word rotated left by k, so wide rows do not
        // repeat the same 32-bit pattern across the row.
        for (int k = 0; k < CHUNKS; k++) begin
          wide[k*32 +: 32] = rotl32(x, 5'(k));
        end
        res = wide[ARENA_WIDTH-1:0];
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Next-state, next-output and generator update; arena_row_select doubles
  // as the row counter since it always holds the row being written.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rng_d    = rng_q;
    rng_src  = rng_q;
    ready_d  = 1'b0;
    write_d  = 1'b0;
    row_d    = 10'd0;
    cols_d   = '0;
    gen_load = 1'b0;
    gen_mode = mode_q;
    gen_row  = 10'd0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
`ifdef ARENA_SEEDER_SEED_EN
        // Reload happens before row 0 is generated, so a simultaneous
        // start already uses the new seed.
        if (seed_load) begin
          rng_src = (seed == 32'h0) ? DEFAULT_SEED : seed;
          rng_d   = rng_src;
        end
`endif
        if (start) begin
          state_d  = RUN;
          mode_d   = mode_t'(mode);
          gen_mode = mode_t'(mode);
          gen_row  = 10'd0;
          gen_load = 1'b1;
          ready_d  = 1'b0;
        end
      end
      RUN: begin
        if (arena_row_select == LAST_ROW) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          gen_row  = arena_row_select + 10'd1;
          gen_load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase

    // The generator only advances when a RANDOM row is actually emitted.
    if (gen_load) begin
      write_d = 1'b1;
      row_d   = gen_row;
      cols_d  = make_row(gen_mode, gen_row[0], rng_src);
      if (gen_mode == MODE_RANDOM) begin
        rng_d = xorshift32(rng_src);
      end
    end
  end

  // State, generator and registered arena outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= IDLE;
      mode_q              <= MODE_CLEAR;
      rng_q               <= SEED_EFF;
      ready               <= 1'b1;
      arena_row_select    <= 10'd0;
      arena_columns_new   <= '0;
      arena_columns_write <= 1'b0;
    end else begin
      state_q             <= state_d;
      mode_q              <= mode_d;
      rng_q               <= rng_d;
      ready               <= ready_d;
      arena_row_select    <= row_d;
      arena_columns_new   <= cols_d;
      arena_columns_write <= write_d;
    end
  end

  assign state_dbg = (state_q == RUN);

endmodule
